// File: rtl/debounce_pkg.sv
// Shared constants for the contact-bounce emulator: FSM encoding and LFSR setup.
package debounce_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BOUNCE = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One step of the right-shifting Galois LFSR (x^16+x^14+x^13+x^11+1).
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Galois LFSR used as the pseudo-random source for bounce phase widths.
module bounce_lfsr
  import debounce_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        iadv,
  output logic [15:0] ostate
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Advance only when the prescaler ticks.
  always_comb begin
    lfsr_d = iadv ? lfsr_next(lfsr_q) : lfsr_q;
  end

  // State register; SEED must be nonzero so the sequence never locks at 0.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) lfsr_q <= SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign ostate = lfsr_q;

endmodule

// File: rtl/switch_bounce_gen.sv
// Contact-bounce emulator: turns a clean level into a burst of random-width
// glitches followed by a settled level, or passes the level through when disabled.
//
//   state  | meaning
//   IDLE   | bypass (ienable=0) or waiting for ilevel != oswitch
//   BOUNCE | toggling oswitch, one toggle per random-width phase
//   SETTLE | holding target for SETTLE_TICKS ticks, then odone
module switch_bounce_gen
  import debounce_pkg::*;
#(
  parameter int          TICK_CNT_MAX = 100,
  parameter int          BOUNCE_MAX   = 4,
  parameter logic [7:0]  WIDTH_MASK   = 8'h07,
  parameter int          SETTLE_TICKS = 16,
  parameter logic [15:0] SEED         = DEFAULT_SEED
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       ienable,
  input  logic       ilevel,
  output logic       oswitch,
  output logic       obusy,
  output logic       odone,
  output logic [7:0] obounce_cnt
);

  localparam logic [15:0] TICK_TC   = 16'(TICK_CNT_MAX);
  localparam logic [7:0]  BCNT_INIT = 8'(2 * BOUNCE_MAX);
  localparam logic [8:0]  SETTLE_PH = 9'(SETTLE_TICKS);

  logic [15:0] cnt_q, cnt_d;
  logic        tick;
  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic [8:0]  width;

  logic [1:0]  state_q, state_d;
  logic        sw_q, sw_d;
  logic        target_q, target_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [8:0]  phase_q, phase_d;

  // Free-running prescaler; tick fires on the terminal count and wraps.
  always_comb begin
    tick  = (cnt_q == TICK_TC);
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  end

  bounce_lfsr #(.SEED(SEED)) u_lfsr (
    .iclk   (iclk),
    .irst   (irst),
    .iadv   (tick),
    .ostate (lfsr)
  );

  // Only the low byte shapes the width; 9 bits hold 1+0xFF without wrapping.
  assign width       = {1'b0, lfsr[7:0] & WIDTH_MASK} + 9'd1;
  assign lfsr_unused = ^lfsr[15:8];

  // Sequencer next-state logic.
  always_comb begin
    state_d  = state_q;
    sw_d     = sw_q;
    target_d = target_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    case (state_q)
      IDLE: begin
        if (!ienable) begin
          sw_d = ilevel;
        end else if (ilevel != sw_q) begin
          sw_d     = ilevel;
          target_d = ilevel;
          busy_d   = 1'b1;
          bcnt_d   = BCNT_INIT;
          if (BOUNCE_MAX == 0) begin
            state_d = SETTLE;
            phase_d = SETTLE_PH;
          end else begin
            state_d = BOUNCE;
            phase_d = width;
          end
        end
      end
      BOUNCE: begin
        if (tick) begin
          if (phase_q == 9'd1) begin
            sw_d   = ~sw_q;
            bcnt_d = bcnt_q - 8'd1;
            if (bcnt_q == 8'd1) begin
              state_d = SETTLE;
              phase_d = SETTLE_PH;
            end else begin
              phase_d = width;
            end
          end else begin
            phase_d = phase_q - 9'd1;
          end
        end
      end
      SETTLE: begin
        sw_d = target_q;
        if (tick) begin
          if (phase_q == 9'd1) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            phase_d = phase_q - 9'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      cnt_q    <= 16'd0;
      state_q  <= IDLE;
      sw_q     <= 1'b0;
      target_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcnt_q   <= 8'd0;
      phase_q  <= 9'd0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      sw_q     <= sw_d;
      target_q <= target_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
    end
  end

  assign oswitch     = sw_q;
  assign obusy       = busy_q;
  assign odone       = done_q;
  assign obounce_cnt = bcnt_q;

endmodule
